alu4_acc_seq: RTL

- Sequencing and accumulator stage wrapped around the existing 4-bit add/subtract/zero-test datapath.
- Upstream side: accepts one command per valid/ready handshake and drives the datapath operand and mode inputs from registered values.
- Downstream side: captures the datapath result and carry into a 4-bit accumulator plus flags, then presents a response under valid/ready.
- The datapath itself stays an external combinational instance; this block only registers, sequences and interprets it.

---
 rtl/alu4_acc_seq.sv | 109 ++++++++++
 1 files changed

// File: rtl/alu4_acc_seq.sv
// Command sequencer and accumulator around an external 4-bit add/sub/zero-test datapath.
// Optional build macro: ALU4_ACC_SATURATE_EN clamps ADD/SUB results instead of wrapping.
module alu4_acc_seq #(
  parameter int unsigned      WIDTH    = 4,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_select,
  output logic             alu_au_lu,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_acc,
  output logic             rsp_zero,
  output logic             rsp_carry
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
  typedef enum logic [1:0] {OP_LOAD, OP_ADD, OP_SUB, OP_CMP} op_t;

  state_t           r_state;
  state_t           w_state_next;
  op_t              r_op;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_b;
  logic             r_zero;
  logic             r_carry;

  logic [WIDTH-1:0] w_acc_next;
  logic             w_zero_next;
  logic             w_carry_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_acc   <= ACC_INIT;
      r_b     <= '0;
      r_op    <= OP_LOAD;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && cmd_valid) begin
        r_b  <= cmd_data;
        r_op <= op_t'(cmd_op);
      end
      if (r_state == S_EXEC) begin
        r_acc   <= w_acc_next;
        r_zero  <= w_zero_next;
        r_carry <= w_carry_next;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (cmd_valid) w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_RESP;
      S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Zero flag follows the (possibly clamped) accumulator, except CMP which uses the datapath zero-test bit.
  always_comb begin
    w_acc_next   = r_acc;
    w_carry_next = 1'b0;
    unique case (r_op)
      OP_LOAD: w_acc_next = r_b;
      OP_ADD: begin
        w_acc_next   = alu_res;
        w_carry_next = alu_cout;
`ifdef ALU4_ACC_SATURATE_EN
        if (alu_cout) w_acc_next = '1;
`endif
      end
      OP_SUB: begin
        w_acc_next   = alu_res;
        w_carry_next = alu_cout;
`ifdef ALU4_ACC_SATURATE_EN
        if (!alu_cout) w_acc_next = '0;
`endif
      end
      OP_CMP:  w_carry_next = alu_cout;
      default: w_acc_next = r_acc;
    endcase
    w_zero_next = (r_op == OP_CMP) ? alu_res[0] : (w_acc_next == '0);
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign rsp_valid  = (r_state == S_RESP);
  assign alu_a      = r_acc;
  assign alu_b      = r_b;
  assign alu_select = (r_state == S_EXEC) && (r_op == OP_SUB);
  assign alu_au_lu  = (r_state == S_EXEC) && (r_op == OP_CMP);
  assign rsp_acc    = r_acc;
  assign rsp_zero   = r_zero;
  assign rsp_carry  = r_carry;

endmodule
